// File: rtl/im_loader.sv
// im_loader: streams instruction words from a valid/ready source into the
// instruction memory (IM) macro. The CPU is held in reset until a load completes.
//
// State table:
//   state | meaning
//   IDLE  | after reset; waiting for start, CPU held
//   LOAD  | accepting source words; each accepted word is written one cycle later
//   FLUSH | final IM write in flight; source no longer accepted
//   DONE  | load complete; CPU released; start begins a new load
//   ERR   | requested range runs past the top of IM; CPU held; start retries
//
// Ports:
//   clk, rst         rising-edge clock; synchronous active-low reset
//   start            one-cycle load request (honoured in IDLE, DONE, ERR)
//   base_addr        first IM word address, captured with start
//   word_cnt         number of words to load (0..2^AW), captured with start
//   in_valid/in_data source word stream; in_ready accepts a word
//   im_CEB/WEB/BWEB  IM chip/write/bit enables, active-low
//   im_A/im_DI       IM word address / write data (held while im_CEB=1)
//   busy/done/err    status flags
//   cpu_hold         1 keeps the CPU in reset
//   checksum         running sum mod 2^DW of the accepted words
module im_loader #(
  parameter int AW = 14,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   word_cnt,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          im_CEB,
  output logic          im_WEB,
  output logic [DW-1:0] im_BWEB,
  output logic [AW-1:0] im_A,
  output logic [DW-1:0] im_DI,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_hold,
  output logic [DW-1:0] checksum
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [AW+1:0] IM_WORDS = (AW+2)'(1) << AW;
  localparam logic [AW:0]   REM_LAST = (AW+1)'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  // words still to be accepted; terminal count is the transfer with rem_q == 1
  logic [AW:0]   rem_q, rem_d;

  logic          in_ready_d, ceb_d, web_d, busy_d, done_d, err_d, hold_d;
  logic [AW-1:0] a_d;
  logic [DW-1:0] di_d, bweb_d, cksum_d;
  logic [AW+1:0] end_addr;
  logic          xfer;

  // in_ready is a register that is 1 exactly while in LOAD
  assign xfer     = in_valid & in_ready;
  assign end_addr = {2'b00, base_addr} + {1'b0, word_cnt};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    ceb_d   = 1'b1;
    web_d   = 1'b1;
    a_d     = im_A;
    di_d    = im_DI;
    cksum_d = checksum;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = word_cnt;
          cksum_d = '0;
          if (word_cnt == '0)
            state_d = DONE;
          else if (end_addr > IM_WORDS)
            state_d = ERR;
          else
            state_d = LOAD;
        end
      end
      LOAD: begin
        if (xfer) begin
          ceb_d   = 1'b0;
          web_d   = 1'b0;
          a_d     = addr_q;
          di_d    = in_data;
          cksum_d = checksum + in_data;
          rem_d   = rem_q - REM_LAST;
          // the address stops on the last word so it never passes the range end
          if (rem_q == REM_LAST)
            state_d = FLUSH;
          else
            addr_d = addr_q + AW'(1);
        end
      end
      FLUSH:   state_d = DONE;
      default: state_d = IDLE;
    endcase

    bweb_d     = ceb_d ? '1 : '0;
    in_ready_d = (state_d == LOAD);
    busy_d     = (state_d == LOAD) || (state_d == FLUSH);
    done_d     = (state_d == DONE);
    err_d      = (state_d == ERR);
    hold_d     = (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      in_ready <= 1'b0;
      im_CEB   <= 1'b1;
      im_WEB   <= 1'b1;
      im_BWEB  <= '1;
      im_A     <= '0;
      im_DI    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_hold <= 1'b1;
      checksum <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      in_ready <= in_ready_d;
      im_CEB   <= ceb_d;
      im_WEB   <= web_d;
      im_BWEB  <= bweb_d;
      im_A     <= a_d;
      im_DI    <= di_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      cpu_hold <= hold_d;
      checksum <= cksum_d;
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Directed testbench for im_loader. Inputs change 1ns after the rising edge,
// outputs are checked 1ns after the edge; IM writes are logged on the falling edge.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] base_addr;
  logic [14:0] word_cnt;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready, im_CEB, im_WEB, busy, done, err, cpu_hold;
  logic [31:0] im_BWEB, im_DI, checksum;
  logic [13:0] im_A;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [13:0] wr_a[$];
  logic [31:0] wr_d[$];
  int          wr_cyc[$];

  im_loader #(.AW(14), .DW(32)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .im_CEB(im_CEB), .im_WEB(im_WEB), .im_BWEB(im_BWEB), .im_A(im_A), .im_DI(im_DI),
    .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold), .checksum(checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (im_CEB === 1'b0 && im_WEB === 1'b0) begin
      wr_a.push_back(im_A);
      wr_d.push_back(im_DI);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_a.delete();
    wr_d.delete();
    wr_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; base_addr = '0; word_cnt = '0;
    in_valid = 1'b0; in_data = '0;
    step(); step();
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_checks++; if ({im_CEB, im_WEB} !== 2'b11) begin n_errors++; $display("FAIL reset_ceb_web: got %b want 11", {im_CEB, im_WEB}); end
    n_checks++; if (im_BWEB !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL reset_bweb: got %h want ffffffff", im_BWEB); end
    n_checks++; if ({im_A, im_DI} !== 46'd0) begin n_errors++; $display("FAIL reset_a_di: got %h/%h want 0/0", im_A, im_DI); end
    n_checks++; if ({busy, done, err, cpu_hold} !== 4'b0001) begin n_errors++; $display("FAIL reset_flags: got %b want 0001", {busy, done, err, cpu_hold}); end
    n_checks++; if (checksum !== 32'd0) begin n_errors++; $display("FAIL reset_checksum: got %h want 0", checksum); end
    rst = 1'b1;
    in_valid = 1'b1; in_data = 32'h1234_5678;
    repeat (3) step();
    n_checks++; if ({busy, done, err, cpu_hold, in_ready, im_CEB} !== 6'b000101) begin n_errors++; $display("FAIL idle_hold: got %b want 000101", {busy, done, err, cpu_hold, in_ready, im_CEB}); end
    n_checks++; if (wr_a.size() !== 0) begin n_errors++; $display("FAIL idle_no_write: got %0d writes want 0", wr_a.size()); end
    in_valid = 1'b0;
  endtask

  task automatic test_basic_load();
    logic [31:0] w[4];
    w[0] = 32'h0000_0013; w[1] = 32'h0010_0093; w[2] = 32'h0020_0113; w[3] = 32'h0030_8193;
    clear_log();
    start = 1'b1; base_addr = 14'h0000; word_cnt = 15'd4;
    step();
    start = 1'b0;
    n_checks++; if ({in_ready, busy, cpu_hold} !== 3'b111) begin n_errors++; $display("FAIL basic_enter_load: got %b want 111", {in_ready, busy, cpu_hold}); end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = w[i];
      step();
      n_checks++;
      if ({im_CEB, im_WEB, im_BWEB, im_A, im_DI} !== {2'b00, 32'h0, 14'(i), w[i]}) begin
        n_errors++;
        $display("FAIL basic_write%0d: got ceb=%b web=%b bweb=%h a=%h di=%h want 0 0 0 %h %h",
                 i, im_CEB, im_WEB, im_BWEB, im_A, im_DI, 14'(i), w[i]);
      end
    end
    // source keeps offering a word while the loader is in FLUSH; it must be ignored
    in_data = 32'hDEAD_BEEF;
    n_checks++; if ({in_ready, busy, done} !== 3'b010) begin n_errors++; $display("FAIL basic_flush: got %b want 010", {in_ready, busy, done}); end
    step();
    in_valid = 1'b0;
    n_checks++; if ({done, cpu_hold, busy, im_CEB} !== 4'b1001) begin n_errors++; $display("FAIL basic_done: got %b want 1001", {done, cpu_hold, busy, im_CEB}); end
    n_checks++; if (checksum !== 32'h0060_834C) begin n_errors++; $display("FAIL basic_checksum: got %h want 0060834c", checksum); end
    n_checks++; if (im_A !== 14'd3 || im_DI !== w[3]) begin n_errors++; $display("FAIL basic_hold_a_di: got %h/%h want 3/%h", im_A, im_DI, w[3]); end
    step();
    n_checks++;
    if (wr_a.size() !== 4 || wr_cyc[3] - wr_cyc[0] !== 3) begin
      n_errors++;
      $display("FAIL basic_consecutive: got %0d writes want 4 on consecutive cycles", wr_a.size());
    end
  endtask

  task automatic test_stall_and_ignored_start();
    clear_log();
    start = 1'b1; base_addr = 14'h3FFE; word_cnt = 15'd2;
    step();
    start = 1'b0;
    n_checks++; if ({cpu_hold, done, busy} !== 3'b101) begin n_errors++; $display("FAIL stall_restart_flags: got %b want 101", {cpu_hold, done, busy}); end
    in_valid = 1'b1; in_data = 32'h0000_000A;
    step();
    n_checks++; if (im_CEB !== 1'b0 || im_A !== 14'h3FFE) begin n_errors++; $display("FAIL stall_w0: got ceb=%b a=%h want 0 3ffe", im_CEB, im_A); end
    // bubble; a start during LOAD must have no effect
    in_valid = 1'b0; in_data = 32'h0000_000B;
    start = 1'b1; base_addr = 14'h0000; word_cnt = 15'd5;
    step();
    start = 1'b0;
    n_checks++; if (im_CEB !== 1'b1 || im_WEB !== 1'b1 || im_A !== 14'h3FFE) begin n_errors++; $display("FAIL stall_bubble: got ceb=%b web=%b a=%h want 1 1 3ffe", im_CEB, im_WEB, im_A); end
    in_valid = 1'b1; in_data = 32'h0000_000C;
    step();
    in_valid = 1'b0;
    n_checks++; if (im_CEB !== 1'b0 || im_A !== 14'h3FFF || im_DI !== 32'hC) begin n_errors++; $display("FAIL stall_w1: got ceb=%b a=%h di=%h want 0 3fff c", im_CEB, im_A, im_DI); end
    step();
    n_checks++; if ({done, err, busy} !== 3'b100) begin n_errors++; $display("FAIL stall_done: got %b want 100", {done, err, busy}); end
    n_checks++; if (checksum !== 32'h0000_0016) begin n_errors++; $display("FAIL stall_checksum: got %h want 16", checksum); end
    step();
    n_checks++; if (wr_a.size() !== 2) begin n_errors++; $display("FAIL stall_count: got %0d writes want 2", wr_a.size()); end
  endtask

  task automatic test_range_error();
    clear_log();
    start = 1'b1; base_addr = 14'h3FFF; word_cnt = 15'd2;
    step();
    start = 1'b0;
    n_checks++; if ({err, cpu_hold, busy, in_ready, done} !== 5'b11000) begin n_errors++; $display("FAIL range_err: got %b want 11000", {err, cpu_hold, busy, in_ready, done}); end
    in_valid = 1'b1; in_data = 32'h0000_0099;
    repeat (3) step();
    n_checks++; if (wr_a.size() !== 0 || err !== 1'b1) begin n_errors++; $display("FAIL range_no_write: got %0d writes err=%b want 0 1", wr_a.size(), err); end
    in_valid = 1'b0;
    start = 1'b1; base_addr = 14'h3FFF; word_cnt = 15'd1;
    step();
    start = 1'b0;
    n_checks++; if ({err, busy, in_ready} !== 3'b011) begin n_errors++; $display("FAIL range_retry: got %b want 011", {err, busy, in_ready}); end
    in_valid = 1'b1; in_data = 32'h0000_0055;
    step();
    in_valid = 1'b0;
    n_checks++; if (im_CEB !== 1'b0 || im_A !== 14'h3FFF) begin n_errors++; $display("FAIL range_retry_write: got ceb=%b a=%h want 0 3fff", im_CEB, im_A); end
    step();
    n_checks++; if ({done, err, cpu_hold} !== 3'b100 || checksum !== 32'h55) begin n_errors++; $display("FAIL range_retry_done: got %b cks=%h want 100 55", {done, err, cpu_hold}, checksum); end
  endtask

  task automatic test_zero_length();
    clear_log();
    start = 1'b1; base_addr = 14'h0123; word_cnt = 15'd0;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000_0077;
    n_checks++; if ({done, busy, err, in_ready} !== 4'b1000 || checksum !== 32'd0) begin n_errors++; $display("FAIL zero_done: got %b cks=%h want 1000 0", {done, busy, err, in_ready}, checksum); end
    repeat (3) step();
    in_valid = 1'b0;
    n_checks++; if (wr_a.size() !== 0 || checksum !== 32'd0) begin n_errors++; $display("FAIL zero_no_write: got %0d writes cks=%h want 0 0", wr_a.size(), checksum); end
  endtask

  task automatic test_restart_from_done();
    clear_log();
    start = 1'b1; base_addr = 14'h0010; word_cnt = 15'd1;
    step();
    start = 1'b0;
    n_checks++; if ({cpu_hold, done, in_ready} !== 3'b101) begin n_errors++; $display("FAIL restart_flags: got %b want 101", {cpu_hold, done, in_ready}); end
    in_valid = 1'b1; in_data = 32'h0000_0777;
    step();
    in_valid = 1'b0;
    step();
    n_checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin n_errors++; $display("FAIL restart_done: got done=%b hold=%b want 1 0", done, cpu_hold); end
    n_checks++; if (wr_a.size() !== 1 || wr_a[0] !== 14'h0010 || wr_d[0] !== 32'h777) begin n_errors++; $display("FAIL restart_write: got %0d writes want 1 at 0010", wr_a.size()); end
  endtask

  task automatic test_reset_mid_load();
    clear_log();
    start = 1'b1; base_addr = 14'h0020; word_cnt = 15'd8;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = 32'h100 + 32'(i);
      step();
    end
    in_data = 32'h102;
    rst = 1'b0;
    step();
    n_checks++; if ({im_CEB, im_WEB, in_ready, busy, done, err, cpu_hold} !== 7'b1100001) begin n_errors++; $display("FAIL midrst_flags: got %b want 1100001", {im_CEB, im_WEB, in_ready, busy, done, err, cpu_hold}); end
    n_checks++; if (im_A !== 14'd0 || im_DI !== 32'd0 || checksum !== 32'd0 || im_BWEB !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL midrst_values: got a=%h di=%h cks=%h bweb=%h want 0 0 0 ffffffff", im_A, im_DI, checksum, im_BWEB); end
    rst = 1'b1;
    repeat (3) step();
    in_valid = 1'b0;
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_errors++; $display("FAIL midrst_idle: got busy=%b rdy=%b want 0 0", busy, in_ready); end
    n_checks++;
    if (wr_a.size() !== 2 || wr_a[0] !== 14'h20 || wr_a[1] !== 14'h21 || wr_d[1] !== 32'h101) begin
      n_errors++;
      $display("FAIL midrst_writes: got %0d writes want 2 at 0020,0021", wr_a.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_stall_and_ignored_start();
    test_range_error();
    test_zero_length();
    test_restart_from_done();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
